// File: rtl/axis_cic_decimator.sv
// N-stage CIC decimator: 1-bit delta-sigma stream in, signed OUT_WIDTH samples out at 1/R rate.
// Integrators run per accepted bit, combs and the output register update on the decimation event.
module axis_cic_decimator #(
   parameter int R = 100,
   parameter int M = 1,
   parameter int N = 2
) (
   input  logic                                  aclk,
   input  logic                                  arst_n,
   input  logic                                  s_axis_data_tdata,
   input  logic                                  s_axis_data_tvalid,
   output logic                                  s_axis_data_tready,
   output logic [2 + N*$clog2(R*M)-1:0]          m_axis_data_tdata,
   output logic                                  m_axis_data_tvalid,
   input  logic                                  m_axis_data_tready
);

   localparam int OUT_WIDTH = 2 + N*$clog2(R*M);
   localparam int CW = $clog2(R);
   localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

   logic [OUT_WIDTH-1:0] int_q [N];
   logic [OUT_WIDTH-1:0] int_d [N];
   logic [OUT_WIDTH-1:0] dly_q [N][M];
   logic [OUT_WIDTH-1:0] dly_d [N][M];
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0] m_tdata_q, m_tdata_d;
   logic                 m_tvalid_q, m_tvalid_d;
   logic                 rdy_en_q, rdy_en_d;
   logic                 accept;
   logic                 dec_event;

   // Only the window-closing bit is held off; it would need the output register.
   assign s_axis_data_tready = rdy_en_q &&
                               !(m_tvalid_q && !m_axis_data_tready && (cnt_q == CNT_LAST));
   assign accept             = s_axis_data_tvalid && s_axis_data_tready;
   assign dec_event          = accept && (cnt_q == CNT_LAST);
   assign m_axis_data_tdata  = m_tdata_q;
   assign m_axis_data_tvalid = m_tvalid_q;

   always_comb begin
      logic [OUT_WIDTH-1:0] acc;
      logic [OUT_WIDTH-1:0] stage_in;
      acc      = s_axis_data_tdata ? OUT_WIDTH'(1) : {OUT_WIDTH{1'b1}};
      stage_in = '0;
      rdy_en_d = 1'b1;
      cnt_d    = cnt_q;

      for (int k = 0; k < N; k++) begin
         int_d[k] = int_q[k];
         for (int j = 0; j < M; j++) begin
            dly_d[k][j] = dly_q[k][j];
         end
      end

      // Each stage adds the freshly updated value of the stage before it.
      for (int k = 0; k < N; k++) begin
         acc = int_q[k] + acc;
         if (accept) begin
            int_d[k] = acc;
         end
      end

      if (accept) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end

      stage_in = acc;
      for (int k = 0; k < N; k++) begin
         acc = stage_in - dly_q[k][M-1];
         if (dec_event) begin
            dly_d[k][0] = stage_in;
            for (int j = 1; j < M; j++) begin
               dly_d[k][j] = dly_q[k][j-1];
            end
         end
         stage_in = acc;
      end

      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      if (m_tvalid_q && m_axis_data_tready) begin
         m_tvalid_d = 1'b0;
      end
      if (dec_event) begin
         m_tdata_d  = stage_in;
         m_tvalid_d = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < N; k++) begin
            int_q[k] <= '0;
            for (int j = 0; j < M; j++) begin
               dly_q[k][j] <= '0;
            end
         end
         cnt_q      <= '0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         rdy_en_q   <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            int_q[k] <= int_d[k];
            for (int j = 0; j < M; j++) begin
               dly_q[k][j] <= dly_d[k][j];
            end
         end
         cnt_q      <= cnt_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         rdy_en_q   <= rdy_en_d;
      end
   end

endmodule
